// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: synchronous DEPTH-word store feeding an in-order
// response FIFO with valid/ready to decode. Optional macro INST_ROM_PC_TAG_EN adds inst_pc_o.
module inst_rom_resp #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
`ifdef INST_ROM_PC_TAG_EN
  output logic [ADDR_W-1:0] inst_pc_o,
`endif
  output logic              stall_req_o,
  output logic              overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(FIFO_DEPTH - 1);

  // Handshake: an entry transfers to decode at a rising edge where
  // inst_valid_o=1 and inst_ready_i=1; inst_ready_i is ignored while empty.

  logic [DATA_W-1:0] mem       [DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
`ifdef INST_ROM_PC_TAG_EN
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
`endif

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          stall_q;
  logic          overflow_q;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (count == FULL_CNT);
  assign pop  = (count != '0) && inst_ready_i;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push = ce && (!full || pop);
  assign drop = ce && full && !pop;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count   <= count_next;
      stall_q <= (count_next >= STALL_CNT);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Storage has no reset; nonblocking update gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld_we) mem[ld_addr] <= ld_data;
      if (push) begin
        fifo_data[tail] <= mem[pc];
`ifdef INST_ROM_PC_TAG_EN
        fifo_pc[tail]   <= pc;
`endif
      end
    end
  end

  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? fifo_data[head] : '0;
`ifdef INST_ROM_PC_TAG_EN
  assign inst_pc_o    = inst_valid_o ? fifo_pc[head] : '0;
`endif
  assign stall_req_o  = stall_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: directed scenarios then random traffic, each cycle
// compared against a queue-based model of the fetch responder.
module tb_inst_rom_resp;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int FD = 4;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          ce = 1'b0;
  logic [AW-1:0] pc = '0;
  logic          ld_we = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          inst_ready_i = 1'b0;
  logic [DW-1:0] inst_o;
  logic          inst_valid_o;
  logic          stall_req_o;
  logic          overflow_o;
`ifdef INST_ROM_PC_TAG_EN
  logic [AW-1:0] inst_pc_o;
`endif

  inst_rom_resp dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .pc           (pc),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
`ifdef INST_ROM_PC_TAG_EN
    .inst_pc_o    (inst_pc_o),
`endif
    .stall_req_o  (stall_req_o),
    .overflow_o   (overflow_o)
  );

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] pc_q[$];
  logic [DW-1:0] ref_mem [1 << AW];
  logic          exp_ovf = 1'b0;
  int            compared = 0;
  int            mismatched = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic          nonempty;
    logic [DW-1:0] head_word;
    nonempty  = (exp_q.size() > 0);
    head_word = nonempty ? exp_q[0] : '0;
    chk("inst_valid", DW'(inst_valid_o), DW'(nonempty));
    chk("inst", inst_o, head_word);
    chk("stall_req", DW'(stall_req_o), DW'(exp_q.size() >= FD - 1));
    chk("overflow", DW'(overflow_o), DW'(exp_ovf));
`ifdef INST_ROM_PC_TAG_EN
    chk("inst_pc", DW'(inst_pc_o), nonempty ? DW'(pc_q[0]) : '0);
`endif
  endtask

  // driver: apply one cycle of inputs, advance the model at the edge, check after it
  task automatic step(input logic c, input logic [AW-1:0] p, input logic w,
                      input logic [AW-1:0] la, input logic [DW-1:0] ld,
                      input logic r, input logic rs);
    logic [DW-1:0] word;
    ce = c; pc = p; ld_we = w; ld_addr = la; ld_data = ld;
    inst_ready_i = r; rst = rs;
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      pc_q.delete();
      exp_ovf = 1'b0;
    end else begin
      word = ref_mem[p];
      if (exp_q.size() > 0 && r) begin
        void'(exp_q.pop_front());
        void'(pc_q.pop_front());
      end
      if (c) begin
        if (exp_q.size() < FD) begin
          exp_q.push_back(word);
          pc_q.push_back(p);
        end else begin
          exp_ovf = 1'b1;
        end
      end
      if (w) ref_mem[la] = ld;
    end
    #1;
    check_outputs();
  endtask

  task automatic fetch(input logic [AW-1:0] p, input logic r);
    step(1'b1, p, 1'b0, '0, '0, r, 1'b0);
  endtask

  task automatic idle(input logic r);
    step(1'b0, '0, 1'b0, '0, '0, r, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] v;
    #1;
    do_reset();
    do_reset();

    // program image: fixed words at 0..3, random elsewhere
    for (int a = 0; a < (1 << AW); a++) begin
      case (a)
        0: v = 32'h11111111;
        1: v = 32'h22222222;
        2: v = 32'h33333333;
        3: v = 32'h44444444;
        default: v = $urandom;
      endcase
      step(1'b0, '0, 1'b1, AW'(a), v, 1'b0, 1'b0);
    end

    // basic fetch stream
    for (int i = 0; i < 4; i++) fetch(AW'(i), 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // back-pressure and drop, then drain
    for (int i = 0; i < 5; i++) fetch(AW'(i), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // full queue with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 4; i++) fetch(AW'(i), 1'b0);
    fetch(AW'(0), 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // read/write collision on pc=2
    step(1'b1, AW'(2), 1'b1, AW'(2), 32'hDEADBEEF, 1'b1, 1'b0);
    fetch(AW'(2), 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, '0, 1'b1, AW'(2), 32'h33333333, 1'b0, 1'b0);

    // reset mid-operation with a fetch and load in the reset cycle
    for (int i = 0; i < 5; i++) fetch(AW'(i), 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, AW'(1), 1'b1, AW'(1), 32'hBADC0DE0, 1'b0, 1'b1);
    fetch(AW'(1), 1'b1);
    idle(1'b1);

    // tag ordering
    fetch(AW'(3), 1'b0);
    fetch(AW'(0), 1'b0);
    idle(1'b1);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, (1 << AW) - 1)),
           $urandom_range(0, 7) == 0, AW'($urandom_range(0, (1 << AW) - 1)),
           $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
